// File: rtl/imuldiv_muldiv_dispatch_pkg.sv
// imuldiv_muldiv_dispatch_pkg
// Shared definitions for the mul/div dispatch slice: function-code encodings,
// message field widths, unit identifiers and the steering helper.
package imuldiv_muldiv_dispatch_pkg;

  localparam int FN_W     = 3;
  localparam int OPND_W   = 32;
  localparam int RESULT_W = 64;

  typedef enum logic [FN_W-1:0] {
    IMULDIV_MULDIVREQ_MSG_FN_MUL  = 3'd0,
    IMULDIV_MULDIVREQ_MSG_FN_DIV  = 3'd1,
    IMULDIV_MULDIVREQ_MSG_FN_DIVU = 3'd2,
    IMULDIV_MULDIVREQ_MSG_FN_REM  = 3'd3,
    IMULDIV_MULDIVREQ_MSG_FN_REMU = 3'd4
  } muldiv_fn_e;

  typedef enum logic {
    UNIT_MUL = 1'b0,
    UNIT_DIV = 1'b1
  } unit_id_e;

  // Codes 5-7 are not defined; they fall through to the multiplier so an
  // illegal code still completes instead of wedging the pipeline.
  function automatic unit_id_e fn_target(input logic [FN_W-1:0] fn);
    unit_id_e t;
    case (fn)
      IMULDIV_MULDIVREQ_MSG_FN_DIV,
      IMULDIV_MULDIVREQ_MSG_FN_DIVU,
      IMULDIV_MULDIVREQ_MSG_FN_REM,
      IMULDIV_MULDIVREQ_MSG_FN_REMU: t = UNIT_DIV;
      default:                       t = UNIT_MUL;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/imuldiv_muldiv_dispatch_if.sv
// imuldiv_muldiv_dispatch_if
// Bundles the unified request/response port and the multiplier / divider
// request/response ports of the dispatch stage.
//   slave  : view used by the dispatch block itself
//   master : view used by the surrounding logic (execute stage and units)
interface imuldiv_muldiv_dispatch_if;
  import imuldiv_muldiv_dispatch_pkg::*;

  logic [FN_W-1:0]     muldivreq_msg_fn;
  logic [OPND_W-1:0]   muldivreq_msg_a;
  logic [OPND_W-1:0]   muldivreq_msg_b;
  logic                muldivreq_val;
  logic                muldivreq_rdy;

  logic [RESULT_W-1:0] muldivresp_msg_result;
  logic                muldivresp_val;
  logic                muldivresp_rdy;

  logic [OPND_W-1:0]   mulreq_msg_a;
  logic [OPND_W-1:0]   mulreq_msg_b;
  logic                mulreq_val;
  logic                mulreq_rdy;
  logic [RESULT_W-1:0] mulresp_msg_result;
  logic                mulresp_val;
  logic                mulresp_rdy;

  logic [FN_W-1:0]     divreq_msg_fn;
  logic [OPND_W-1:0]   divreq_msg_a;
  logic [OPND_W-1:0]   divreq_msg_b;
  logic                divreq_val;
  logic                divreq_rdy;
  logic [RESULT_W-1:0] divresp_msg_result;
  logic                divresp_val;
  logic                divresp_rdy;

  modport slave (
    input  muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b, muldivreq_val,
    output muldivreq_rdy,
    output muldivresp_msg_result, muldivresp_val,
    input  muldivresp_rdy,
    output mulreq_msg_a, mulreq_msg_b, mulreq_val,
    input  mulreq_rdy,
    input  mulresp_msg_result, mulresp_val,
    output mulresp_rdy,
    output divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val,
    input  divreq_rdy,
    input  divresp_msg_result, divresp_val,
    output divresp_rdy
  );

  modport master (
    output muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b, muldivreq_val,
    input  muldivreq_rdy,
    input  muldivresp_msg_result, muldivresp_val,
    output muldivresp_rdy,
    input  mulreq_msg_a, mulreq_msg_b, mulreq_val,
    output mulreq_rdy,
    output mulresp_msg_result, mulresp_val,
    input  mulresp_rdy,
    input  divreq_msg_fn, divreq_msg_a, divreq_msg_b, divreq_val,
    output divreq_rdy,
    output divresp_msg_result, divresp_val,
    input  divresp_rdy
  );

endinterface

// File: rtl/imuldiv_muldiv_dispatch_order_queue.sv
// imuldiv_order_queue
// FIFO of 1-bit unit IDs recording the order in which requests were issued.
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   push, push_id  enqueue one ID (ignored when full)
//   pop          dequeue the head (ignored when empty)
//   head         ID at the head (undefined when empty)
//   full, empty  derived from the registered occupancy count only
module imuldiv_order_queue #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic             mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rptr];

  // Storage needs no reset: an entry is only ever read after being written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= push_id;
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imuldiv_muldiv_dispatch.sv
// imuldiv_muldiv_dispatch
// Steers a unified mul/div request stream to the iterative multiplier or
// divider by function code and returns their responses in request order.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   io          imuldiv_muldiv_dispatch_if.slave: unified request/response
//               port plus the multiplier and divider request/response ports
// Parameter:
//   ORDQ_DEPTH  max outstanding requests (power of two, >= 2)
// Build option:
//   IMULDIV_DISPATCH_INREG_EN  adds a one-entry input register in front of
//                              the steering logic (+1 cycle request latency)
module imuldiv_muldiv_dispatch
  import imuldiv_muldiv_dispatch_pkg::*;
#(
  parameter int ORDQ_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  imuldiv_muldiv_dispatch_if.slave      io
);

  logic [FN_W-1:0]   sel_fn;
  logic [OPND_W-1:0] sel_a;
  logic [OPND_W-1:0] sel_b;
  logic              sel_val;
  unit_id_e          target;
  logic              target_rdy;
  logic              fire;

  logic              q_head;
  logic              q_full;
  logic              q_empty;
  logic              resp_val;
  logic              pop;

`ifdef IMULDIV_DISPATCH_INREG_EN
  logic [FN_W-1:0]   inreg_fn;
  logic [OPND_W-1:0] inreg_a;
  logic [OPND_W-1:0] inreg_b;
  logic              inreg_valid;

  assign sel_fn  = inreg_fn;
  assign sel_a   = inreg_a;
  assign sel_b   = inreg_b;
  assign sel_val = inreg_valid;

  // The register may refill in the same cycle it dispatches.
  assign io.muldivreq_rdy = !reset && (!inreg_valid || fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      inreg_valid <= 1'b0;
    end else if (io.muldivreq_val && io.muldivreq_rdy) begin
      inreg_valid <= 1'b1;
    end else if (fire) begin
      inreg_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (io.muldivreq_val && io.muldivreq_rdy) begin
      inreg_fn <= io.muldivreq_msg_fn;
      inreg_a  <= io.muldivreq_msg_a;
      inreg_b  <= io.muldivreq_msg_b;
    end
  end
`else
  assign sel_fn  = io.muldivreq_msg_fn;
  assign sel_a   = io.muldivreq_msg_a;
  assign sel_b   = io.muldivreq_msg_b;
  assign sel_val = io.muldivreq_val;

  // Uses the registered full flag, so a pop this cycle never frees a slot
  // for a push in the same cycle.
  assign io.muldivreq_rdy = !reset && !q_full && target_rdy;
`endif

  assign target     = fn_target(sel_fn);
  assign target_rdy = (target == UNIT_DIV) ? io.divreq_rdy : io.mulreq_rdy;
  assign fire       = !reset && sel_val && target_rdy && !q_full;

  assign io.mulreq_msg_a  = sel_a;
  assign io.mulreq_msg_b  = sel_b;
  assign io.mulreq_val    = !reset && sel_val && (target == UNIT_MUL) && !q_full;

  assign io.divreq_msg_fn = sel_fn;
  assign io.divreq_msg_a  = sel_a;
  assign io.divreq_msg_b  = sel_b;
  assign io.divreq_val    = !reset && sel_val && (target == UNIT_DIV) && !q_full;

  imuldiv_order_queue #(
    .DEPTH (ORDQ_DEPTH)
  ) u_ordq (
    .clk     (clk),
    .reset   (reset),
    .push    (fire),
    .push_id (target),
    .pop     (pop),
    .head    (q_head),
    .full    (q_full),
    .empty   (q_empty)
  );

  // Only the unit at the queue head may hand over a response; the other one
  // sees rdy=0 and holds its result until it becomes head.
  assign resp_val = !reset && !q_empty &&
                    (q_head ? io.divresp_val : io.mulresp_val);
  assign pop      = resp_val && io.muldivresp_rdy;

  assign io.muldivresp_val = resp_val;
  assign io.mulresp_rdy    = !reset && !q_empty && !q_head && io.muldivresp_rdy;
  assign io.divresp_rdy    = !reset && !q_empty &&  q_head && io.muldivresp_rdy;

  always_comb begin
    io.muldivresp_msg_result = '0;
    if (!reset && !q_empty) begin
      io.muldivresp_msg_result = q_head ? io.divresp_msg_result
                                        : io.mulresp_msg_result;
    end
  end

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
module tb_imuldiv_muldiv_dispatch;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  imuldiv_muldiv_dispatch_if bus ();

  imuldiv_muldiv_dispatch #(.ORDQ_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  localparam logic [63:0] DIV_RES = {32'hFFFF_FFFE, 32'hFFFF_FFFD};
  localparam logic [63:0] MUL_RES = 64'hFFFF_FFFF_FFFF_FFEB;
  localparam logic [63:0] HOLD_RES = 64'hDEAD_BEEF_0000_0007;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.muldivreq_msg_fn   = 3'd0;
    bus.muldivreq_msg_a    = '0;
    bus.muldivreq_msg_b    = '0;
    bus.muldivreq_val      = 1'b0;
    bus.muldivresp_rdy     = 1'b1;
    bus.mulreq_rdy         = 1'b1;
    bus.mulresp_msg_result = '0;
    bus.mulresp_val        = 1'b0;
    bus.divreq_rdy         = 1'b1;
    bus.divresp_msg_result = '0;
    bus.divresp_val        = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.muldivreq_val = 1'b1; bus.muldivreq_msg_a = 32'd1; bus.muldivreq_msg_b = 32'd2;
    bus.mulresp_val = 1'b1; bus.mulresp_msg_result = 64'h55; bus.divresp_val = 1'b1;
    cyc();
    #1;
    checks++; if (bus.muldivreq_rdy !== 1'b0) begin errors++; $display("FAIL rst_req_rdy got %0b want 0", bus.muldivreq_rdy); end
    checks++; if (bus.mulreq_val !== 1'b0 || bus.divreq_val !== 1'b0) begin errors++; $display("FAIL rst_unit_val got %0b%0b want 00", bus.mulreq_val, bus.divreq_val); end
    checks++; if (bus.muldivresp_val !== 1'b0 || bus.muldivresp_msg_result !== 64'd0) begin errors++; $display("FAIL rst_resp got val %0b res %0h want 0 0", bus.muldivresp_val, bus.muldivresp_msg_result); end
    checks++; if (bus.mulresp_rdy !== 1'b0 || bus.divresp_rdy !== 1'b0) begin errors++; $display("FAIL rst_unit_rdy got %0b%0b want 00", bus.mulresp_rdy, bus.divresp_rdy); end
    reset = 1'b0;
    bus.muldivreq_val = 1'b0;
    #1;
    checks++; if (bus.muldivresp_val !== 1'b0 || bus.mulresp_rdy !== 1'b0 || bus.muldivresp_msg_result !== 64'd0) begin errors++; $display("FAIL empty_gate got val %0b rdy %0b res %0h want 0 0 0", bus.muldivresp_val, bus.mulresp_rdy, bus.muldivresp_msg_result); end
    checks++; if (bus.muldivreq_rdy !== 1'b1) begin errors++; $display("FAIL post_rst_req_rdy got %0b want 1", bus.muldivreq_rdy); end
    cyc();
    idle_inputs();
  endtask

  task automatic test_mul_div_order();
    bus.muldivreq_val = 1'b1; bus.muldivreq_msg_fn = 3'd0;
    bus.muldivreq_msg_a = 32'd7; bus.muldivreq_msg_b = 32'hFFFF_FFFD;
    #1;
    checks++; if (bus.mulreq_val !== 1'b1 || bus.divreq_val !== 1'b0 || bus.muldivreq_rdy !== 1'b1) begin errors++; $display("FAIL mul_steer got mv %0b dv %0b rdy %0b want 1 0 1", bus.mulreq_val, bus.divreq_val, bus.muldivreq_rdy); end
    checks++; if (bus.mulreq_msg_a !== 32'd7 || bus.mulreq_msg_b !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mul_opnd got %0h %0h want 7 fffffffd", bus.mulreq_msg_a, bus.mulreq_msg_b); end
    cyc();
    bus.muldivreq_msg_fn = 3'd1; bus.muldivreq_msg_a = 32'hFFFF_FFEC; bus.muldivreq_msg_b = 32'd6;
    #1;
    checks++; if (bus.divreq_val !== 1'b1 || bus.mulreq_val !== 1'b0 || bus.muldivreq_rdy !== 1'b1) begin errors++; $display("FAIL div_steer got dv %0b mv %0b rdy %0b want 1 0 1", bus.divreq_val, bus.mulreq_val, bus.muldivreq_rdy); end
    checks++; if (bus.divreq_msg_fn !== 3'd1 || bus.divreq_msg_a !== 32'hFFFF_FFEC || bus.divreq_msg_b !== 32'd6) begin errors++; $display("FAIL div_msg got %0d %0h %0h want 1 ffffffec 6", bus.divreq_msg_fn, bus.divreq_msg_a, bus.divreq_msg_b); end
    cyc();
    bus.muldivreq_val = 1'b0;
    bus.divresp_val = 1'b1; bus.divresp_msg_result = DIV_RES;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.divresp_rdy !== 1'b0 || bus.muldivresp_val !== 1'b0) begin errors++; $display("FAIL div_held cyc %0d got rdy %0b val %0b want 0 0", i, bus.divresp_rdy, bus.muldivresp_val); end
      cyc();
    end
    bus.mulresp_val = 1'b1; bus.mulresp_msg_result = MUL_RES;
    #1;
    checks++; if (bus.muldivresp_val !== 1'b1 || bus.muldivresp_msg_result !== MUL_RES) begin errors++; $display("FAIL first_resp got val %0b res %0h want 1 %0h", bus.muldivresp_val, bus.muldivresp_msg_result, MUL_RES); end
    checks++; if (bus.mulresp_rdy !== 1'b1 || bus.divresp_rdy !== 1'b0) begin errors++; $display("FAIL first_rdy got m %0b d %0b want 1 0", bus.mulresp_rdy, bus.divresp_rdy); end
    cyc();
    bus.mulresp_val = 1'b0;
    #1;
    checks++; if (bus.muldivresp_val !== 1'b1 || bus.muldivresp_msg_result !== DIV_RES) begin errors++; $display("FAIL second_resp got val %0b res %0h want 1 %0h", bus.muldivresp_val, bus.muldivresp_msg_result, DIV_RES); end
    checks++; if (bus.divresp_rdy !== 1'b1 || bus.mulresp_rdy !== 1'b0) begin errors++; $display("FAIL second_rdy got d %0b m %0b want 1 0", bus.divresp_rdy, bus.mulresp_rdy); end
    cyc();
    #1;
    checks++; if (bus.muldivresp_val !== 1'b0 || bus.divresp_rdy !== 1'b0 || bus.muldivresp_msg_result !== 64'd0) begin errors++; $display("FAIL drained got val %0b rdy %0b res %0h want 0 0 0", bus.muldivresp_val, bus.divresp_rdy, bus.muldivresp_msg_result); end
    idle_inputs();
  endtask

  task automatic test_illegal_fn();
    bus.muldivreq_val = 1'b1; bus.muldivreq_msg_fn = 3'd6;
    bus.muldivreq_msg_a = 32'd5; bus.muldivreq_msg_b = 32'd4; bus.divreq_rdy = 1'b0;
    #1;
    checks++; if (bus.mulreq_val !== 1'b1 || bus.divreq_val !== 1'b0 || bus.muldivreq_rdy !== 1'b1) begin errors++; $display("FAIL fn6_steer got mv %0b dv %0b rdy %0b want 1 0 1", bus.mulreq_val, bus.divreq_val, bus.muldivreq_rdy); end
    cyc();
    bus.muldivreq_msg_fn = 3'd4;
    #1;
    checks++; if (bus.divreq_val !== 1'b1 || bus.mulreq_val !== 1'b0 || bus.muldivreq_rdy !== 1'b0) begin errors++; $display("FAIL fn4_blocked got dv %0b mv %0b rdy %0b want 1 0 0", bus.divreq_val, bus.mulreq_val, bus.muldivreq_rdy); end
    bus.muldivreq_msg_fn = 3'd7;
    #1;
    checks++; if (bus.mulreq_val !== 1'b1 || bus.divreq_val !== 1'b0) begin errors++; $display("FAIL fn7_steer got mv %0b dv %0b want 1 0", bus.mulreq_val, bus.divreq_val); end
    bus.muldivreq_msg_fn = 3'd4;
    cyc();
    bus.muldivreq_val = 1'b0;
    bus.mulresp_val = 1'b1; bus.mulresp_msg_result = 64'd20;
    #1;
    checks++; if (bus.muldivresp_val !== 1'b1 || bus.muldivresp_msg_result !== 64'd20) begin errors++; $display("FAIL fn6_resp got val %0b res %0h want 1 14", bus.muldivresp_val, bus.muldivresp_msg_result); end
    cyc();
    bus.divresp_val = 1'b1;
    #1;
    checks++; if (bus.muldivresp_val !== 1'b0) begin errors++; $display("FAIL fn4_not_pushed got val %0b want 0", bus.muldivresp_val); end
    idle_inputs();
  endtask

  task automatic test_full();
    bus.muldivreq_val = 1'b1; bus.muldivreq_msg_fn = 3'd0;
    for (int i = 0; i < 4; i++) begin
      bus.muldivreq_msg_a = 32'(i);
      #1;
      checks++; if (bus.muldivreq_rdy !== 1'b1) begin errors++; $display("FAIL fill_rdy req %0d got %0b want 1", i, bus.muldivreq_rdy); end
      cyc();
    end
    #1;
    checks++; if (bus.muldivreq_rdy !== 1'b0 || bus.mulreq_val !== 1'b0) begin errors++; $display("FAIL full_block got rdy %0b mv %0b want 0 0", bus.muldivreq_rdy, bus.mulreq_val); end
    bus.mulresp_val = 1'b1; bus.mulresp_msg_result = 64'h11;
    #1;
    checks++; if (bus.muldivresp_val !== 1'b1 || bus.mulresp_rdy !== 1'b1 || bus.muldivreq_rdy !== 1'b0) begin errors++; $display("FAIL full_pop_push got val %0b mrdy %0b rdy %0b want 1 1 0", bus.muldivresp_val, bus.mulresp_rdy, bus.muldivreq_rdy); end
    cyc();
    bus.muldivreq_val = 1'b0; bus.mulresp_val = 1'b0;
    #1;
    checks++; if (bus.muldivreq_rdy !== 1'b1) begin errors++; $display("FAIL after_pop_rdy got %0b want 1", bus.muldivreq_rdy); end
  endtask

  task automatic test_backpressure();
    bus.mulresp_val = 1'b1; bus.mulresp_msg_result = HOLD_RES; bus.muldivresp_rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (bus.muldivresp_val !== 1'b1 || bus.muldivresp_msg_result !== HOLD_RES || bus.mulresp_rdy !== 1'b0) begin errors++; $display("FAIL stall cyc %0d got val %0b res %0h rdy %0b want 1 %0h 0", i, bus.muldivresp_val, bus.muldivresp_msg_result, bus.mulresp_rdy, HOLD_RES); end
      cyc();
    end
    bus.mulresp_val = 1'b0; bus.muldivreq_val = 1'b1; bus.muldivreq_msg_fn = 3'd0;
    #1;
    checks++; if (bus.muldivreq_rdy !== 1'b1) begin errors++; $display("FAIL stall_count_rdy got %0b want 1", bus.muldivreq_rdy); end
    cyc();
    bus.muldivreq_val = 1'b0;
    #1;
    checks++; if (bus.muldivreq_rdy !== 1'b0) begin errors++; $display("FAIL stall_count_full got %0b want 0", bus.muldivreq_rdy); end
    bus.mulresp_val = 1'b1; bus.muldivresp_rdy = 1'b1;
    cyc();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    bus.mulresp_val = 1'b1; bus.divresp_val = 1'b1;
    #1;
    checks++; if (bus.muldivresp_val !== 1'b0 || bus.mulresp_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_gate got val %0b rdy %0b want 0 0", bus.muldivresp_val, bus.mulresp_rdy); end
    cyc();
    reset = 1'b0;
    #1;
    checks++; if (bus.muldivresp_val !== 1'b0 || bus.mulresp_rdy !== 1'b0 || bus.divresp_rdy !== 1'b0) begin errors++; $display("FAIL mid_rst_empty got val %0b m %0b d %0b want 0 0 0", bus.muldivresp_val, bus.mulresp_rdy, bus.divresp_rdy); end
    bus.mulresp_val = 1'b0; bus.divresp_val = 1'b0;
    bus.muldivreq_val = 1'b1; bus.muldivreq_msg_fn = 3'd0;
    bus.muldivreq_msg_a = 32'd3; bus.muldivreq_msg_b = 32'd3;
    #1;
    checks++; if (bus.muldivreq_rdy !== 1'b1 || bus.mulreq_val !== 1'b1) begin errors++; $display("FAIL mid_rst_req got rdy %0b mv %0b want 1 1", bus.muldivreq_rdy, bus.mulreq_val); end
    cyc();
    bus.muldivreq_val = 1'b0; bus.mulresp_val = 1'b1; bus.mulresp_msg_result = 64'd9;
    #1;
    checks++; if (bus.muldivresp_val !== 1'b1 || bus.muldivresp_msg_result !== 64'd9) begin errors++; $display("FAIL mid_rst_resp got val %0b res %0h want 1 9", bus.muldivresp_val, bus.muldivresp_msg_result); end
    cyc();
    #1;
    checks++; if (bus.muldivresp_val !== 1'b0) begin errors++; $display("FAIL mid_rst_drain got %0b want 0", bus.muldivresp_val); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    bus.muldivreq_val = 1'b1; bus.muldivreq_msg_fn = 3'd0; bus.muldivreq_msg_a = 32'd1;
    cyc();
    bus.muldivreq_msg_a = 32'd2;
    bus.mulresp_val = 1'b1; bus.mulresp_msg_result = 64'hA1;
    #1;
    checks++; if (bus.muldivreq_rdy !== 1'b1 || bus.muldivresp_val !== 1'b1 || bus.muldivresp_msg_result !== 64'hA1) begin errors++; $display("FAIL b2b_both got rdy %0b val %0b res %0h want 1 1 a1", bus.muldivreq_rdy, bus.muldivresp_val, bus.muldivresp_msg_result); end
    cyc();
    bus.muldivreq_val = 1'b0; bus.mulresp_msg_result = 64'hA2;
    #1;
    checks++; if (bus.muldivresp_val !== 1'b1 || bus.muldivresp_msg_result !== 64'hA2) begin errors++; $display("FAIL b2b_second got val %0b res %0h want 1 a2", bus.muldivresp_val, bus.muldivresp_msg_result); end
    cyc();
    #1;
    checks++; if (bus.muldivresp_val !== 1'b0) begin errors++; $display("FAIL b2b_drain got %0b want 0", bus.muldivresp_val); end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_mul_div_order();
    test_illegal_fn();
    test_full();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imuldiv_muldiv_dispatch.md
# imuldiv_muldiv_dispatch

Front-end dispatch stage for the iterative integer mul/div subsystem. It accepts one unified mul/div request stream, steers each request to the iterative multiplier or divider by function code, and returns their responses on one unified response port in strict request order. It sits between the processor's execute stage and the two iterative units, so those units never see an interleaved request stream.

## Interface
- ORDQ_DEPTH, 4: max outstanding requests tracked by the order queue (power of 2, ≥2)
- clk  in  1  clock, all state on posedge
- reset  in  1  synchronous, active-high
- muldivreq_msg_fn  in  3  0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU; 5–7 illegal
- muldivreq_msg_a  in  32  operand A
- muldivreq_msg_b  in  32  operand B
- muldivreq_val  in  1  request valid
- muldivreq_rdy  out  1  request ready
- muldivresp_msg_result  out  64  result from the unit at the order-queue head
- muldivresp_val  out  1  response valid
- muldivresp_rdy  in  1  response ready
- mulreq_msg_a, mulreq_msg_b  out  32 each  multiplier operands
- mulreq_val  out  1; mulreq_rdy  in  1
- mulresp_msg_result  in  64; mulresp_val  in  1; mulresp_rdy  out  1
- divreq_msg_fn  out  3  fn passed through unchanged (DIV..REMU)
- divreq_msg_a, divreq_msg_b  out  32 each
- divreq_val  out  1; divreq_rdy  in  1
- divresp_msg_result  in  64; divresp_val  in  1; divresp_rdy  out  1

## Operation
- Target select: fn==MUL or fn 5–7 goes to MUL, so illegal codes execute as MUL. fn 1–4 goes to DIV.
- Order queue: FIFO of 1-bit unit IDs (0 MUL, 1 DIV) with ORDQ_DEPTH entries, plus a count register of log2(ORDQ_DEPTH)+1 bits.
- Accept (no input register): fire when muldivreq_val, the target unit's rdy and !full are all high. The same cycle pushes the unit ID.
- mulreq_val = muldivreq_val && target==MUL && !full. divreq_val is the analogue for DIV. The non-target val is 0.
- muldivreq_rdy = !full && target rdy.
- Return path:
  - head = FIFO head.
  - muldivresp_val = !empty && (head ? divresp_val : mulresp_val).
  - mulresp_rdy = !empty && head==0 && muldivresp_rdy. divresp_rdy is the analogue for head==1.
  - muldivresp_msg_result = head ? divresp : mulresp. It is 0 when empty.
- Pop on muldivresp_val && muldivresp_rdy.
- A response arriving from the non-head unit is held off (its rdy stays 0) until it becomes head.
- Full: accept is blocked even if a pop happens the same cycle. rdy depends only on the registered count plus the unit rdy.
- Empty: all response-side val/rdy are 0. No push-to-pop bypass is allowed; the units have ≥1 cycle latency.
- Simultaneous push and pop when neither full nor empty: count is unchanged and both pointers advance.
- Pointers wrap modulo ORDQ_DEPTH.

## Timing
- Reset: count=0 and pointers=0.
  - While reset is high, every val/rdy output is forced to 0 and result outputs are 0.
  - Reset mid-operation discards all tracked requests. The units share this reset, so no stale responses remain.
- Request path: combinational, 0 cycles added (without the macro).
- Response path: combinational, 0 cycles added.
- End-to-end latency = unit latency (+1 with the macro).
- Throughput: one accept and one return per cycle.

## Configuration
- IMULDIV_DISPATCH_INREG_EN defined:
  - A one-entry input register (fn, a, b, valid) sits between the unified port and the steering logic.
  - muldivreq_rdy = !inreg_valid || inreg_fire, where inreg_fire is the dispatch of the register to its unit under the Accept rule.
  - Queue push occurs on inreg_fire. Request latency is +1 cycle.
  - Reset clears inreg_valid.
- Undefined: no register; behaviour is exactly as in Operation.

## Structure
- Shared include imuldiv-MulDivReqMsg.v holds:
  - fn encodings as localparams/macros (IMULDIV_MULDIVREQ_MSG_FN_MUL, _DIV, _DIVU, _REM, _REMU);
  - field widths (fn 3, operand 32, result 64).
- Sub-module imuldiv_order_queue: parameterized 1-bit FIFO (push, pop, head, full, empty), reusable by later out-of-order-capable units.
- The top module holds only steering, the optional input register, and the muxes.

## Test plan
- MUL 7×-3 then DIV -20/6: mulreq_val then divreq_val in consecutive cycles. Results return in order (-21, then {rem -2, quot -3}) even with the divider responding first.
- Divider finishes early while MUL is head: divresp_rdy stays 0 until the MUL result pops. No reorder, no drop.
- ORDQ_DEPTH=4, units never respond: the 4th request is accepted and muldivreq_rdy=0 on the 5th. A pop and a push in the same full cycle → push refused that cycle.
- muldivresp_rdy=0 for 10 cycles with a result valid: result is held stable, no pop, unit rdy=0.
- fn=6 with a=5, b=4: routed to the multiplier, response 20.
- Reset asserted with 3 outstanding: next cycle all vals=0 and count=0. A new MUL request after reset completes normally.
